// File: rtl/prf_scoreboard.sv
// Physical register file with per-register ready scoreboard, flush recovery and sticky
// write-collision flag. Define PRF_BYPASS_EN to forward same-cycle CDB writes to reads.
module prf_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NPREG  = 64,
  parameter int unsigned NREAD  = 10,
  parameter int unsigned NWRITE = 5,
  parameter int unsigned NALLOC = 2,
  localparam int unsigned PW    = $clog2(NPREG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREAD*PW-1:0]      rd_addr,
  output logic [NREAD*DATA_W-1:0]  rd_data,
  output logic [NREAD-1:0]         rd_ready,
  input  logic [NWRITE-1:0]        wr_valid,
  input  logic [NWRITE*PW-1:0]     wr_addr,
  input  logic [NWRITE*DATA_W-1:0] wr_data,
  input  logic [NALLOC-1:0]        alloc_valid,
  input  logic [NALLOC*PW-1:0]     alloc_addr,
  input  logic                     flush,
  output logic                     wr_collide,
  input  logic                     collide_clr
);

  logic [DATA_W-1:0] mem_q [NPREG];
  logic [DATA_W-1:0] mem_d [NPREG];
  logic [NPREG-1:0]  ready_q, ready_d;
  logic              collide_q, collide_d;
  logic              collide_hit;

  always_comb begin
    logic [PW-1:0] wa;
    logic [PW-1:0] wb;
    logic [PW-1:0] aa;
    wa          = '0;
    wb          = '0;
    aa          = '0;
    mem_d       = mem_q;
    ready_d     = ready_q;
    collide_hit = 1'b0;

    // Ascending port order lets the highest-indexed writer win a collision.
    for (int unsigned i = 0; i < NWRITE; i++) begin
      wa = wr_addr[i*PW +: PW];
      if (wr_valid[i] && (wa != '0)) begin
        mem_d[wa]   = wr_data[i*DATA_W +: DATA_W];
        ready_d[wa] = 1'b1;
      end
      for (int unsigned k = i + 1; k < NWRITE; k++) begin
        wb = wr_addr[k*PW +: PW];
        if (wr_valid[i] && wr_valid[k] && (wa != '0) && (wa == wb)) begin
          collide_hit = 1'b1;
        end
      end
    end

    // Allocation clears override the write's ready set; flush overrides both.
    if (flush) begin
      ready_d = '1;
    end else begin
      for (int unsigned j = 0; j < NALLOC; j++) begin
        aa = alloc_addr[j*PW +: PW];
        if (alloc_valid[j] && (aa != '0)) begin
          ready_d[aa] = 1'b0;
        end
      end
    end

    mem_d[0]   = '0;
    ready_d[0] = 1'b1;

    if (collide_clr) begin
      collide_d = 1'b0;
    end else if (collide_hit) begin
      collide_d = 1'b1;
    end else begin
      collide_d = collide_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q     <= '{default: '0};
      ready_q   <= '1;
      collide_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      ready_q   <= ready_d;
      collide_q <= collide_d;
    end
  end

  assign wr_collide = collide_q;

  always_comb begin
    logic [PW-1:0] ra;
    ra       = '0;
    rd_data  = '0;
    rd_ready = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      ra = rd_addr[p*PW +: PW];
      if (ra == '0) begin
        rd_data[p*DATA_W +: DATA_W] = '0;
        rd_ready[p]                 = 1'b1;
      end else begin
        rd_data[p*DATA_W +: DATA_W] = mem_q[ra];
        rd_ready[p]                 = ready_q[ra];
`ifdef PRF_BYPASS_EN
        for (int unsigned i = 0; i < NWRITE; i++) begin
          if (wr_valid[i] && (wr_addr[i*PW +: PW] == ra)) begin
            rd_data[p*DATA_W +: DATA_W] = wr_data[i*DATA_W +: DATA_W];
            rd_ready[p]                 = 1'b1;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_prf_scoreboard.sv
// Randomised and directed bench for prf_scoreboard: a reference model pushes expected read
// results into a queue that a negedge monitor drains and compares against the DUT.
module tb_prf_scoreboard;
  localparam int DATA_W = 32;
  localparam int NPREG  = 64;
  localparam int NREAD  = 10;
  localparam int NWRITE = 5;
  localparam int NALLOC = 2;
  localparam int PW     = $clog2(NPREG);

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NREAD*PW-1:0]      rd_addr;
  logic [NREAD*DATA_W-1:0]  rd_data;
  logic [NREAD-1:0]         rd_ready;
  logic [NWRITE-1:0]        wr_valid;
  logic [NWRITE*PW-1:0]     wr_addr;
  logic [NWRITE*DATA_W-1:0] wr_data;
  logic [NALLOC-1:0]        alloc_valid;
  logic [NALLOC*PW-1:0]     alloc_addr;
  logic                     flush;
  logic                     wr_collide;
  logic                     collide_clr;

  prf_scoreboard #(
    .DATA_W (DATA_W),
    .NPREG  (NPREG),
    .NREAD  (NREAD),
    .NWRITE (NWRITE),
    .NALLOC (NALLOC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .flush       (flush),
    .wr_collide  (wr_collide),
    .collide_clr (collide_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                port;  // -1 selects the wr_collide check
    logic [DATA_W-1:0] data;
    logic              ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  logic [DATA_W-1:0] m_data  [NPREG];
  bit                m_ready [NPREG];
  bit                m_collide;

  task automatic model_reset();
    for (int a = 0; a < NPREG; a++) begin
      m_data[a]  = '0;
      m_ready[a] = 1'b1;
    end
    m_collide = 1'b0;
  endtask

  // Apply the inputs present at the posedge just taken.
  task automatic model_update();
    int cnt     [NPREG];
    bit written [NPREG];
    bit alloced [NPREG];
    bit hit;
    if (!rst) return;
    hit = 1'b0;
    for (int a = 0; a < NPREG; a++) begin
      cnt[a] = 0; written[a] = 1'b0; alloced[a] = 1'b0;
    end
    for (int i = 0; i < NWRITE; i++) begin
      int a;
      a = int'(wr_addr[i*PW +: PW]);
      if (wr_valid[i] && a != 0) begin
        cnt[a]++;
        written[a] = 1'b1;
        m_data[a]  = wr_data[i*DATA_W +: DATA_W];
      end
    end
    for (int j = 0; j < NALLOC; j++) begin
      int a;
      a = int'(alloc_addr[j*PW +: PW]);
      if (alloc_valid[j] && a != 0) alloced[a] = 1'b1;
    end
    for (int a = 1; a < NPREG; a++) begin
      if (cnt[a] > 1) hit = 1'b1;
      if (flush) m_ready[a] = 1'b1;
      else if (alloced[a]) m_ready[a] = 1'b0;
      else if (written[a]) m_ready[a] = 1'b1;
    end
    if (collide_clr) m_collide = 1'b0;
    else if (hit) m_collide = 1'b1;
  endtask

  task automatic expect_now();
    for (int p = 0; p < NREAD; p++) begin
      exp_t e;
      int   a;
      a = int'(rd_addr[p*PW +: PW]);
      e.port  = p;
      e.data  = m_data[a];
      e.ready = m_ready[a];
      if (a == 0) begin
        e.data  = '0;
        e.ready = 1'b1;
      end
`ifdef PRF_BYPASS_EN
      else begin
        for (int i = 0; i < NWRITE; i++) begin
          if (wr_valid[i] && int'(wr_addr[i*PW +: PW]) == a) begin
            e.data  = wr_data[i*DATA_W +: DATA_W];
            e.ready = 1'b1;
          end
        end
      end
`endif
      exp_q.push_back(e);
    end
    exp_q.push_back('{port: -1, data: '0, ready: m_collide});
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (e.port < 0) begin
        if (wr_collide !== e.ready) begin
          n_fails++;
          $display("FAIL wr_collide: got %b want %b at %0t", wr_collide, e.ready, $time);
        end
      end else if (rd_data[e.port*DATA_W +: DATA_W] !== e.data
                   || rd_ready[e.port] !== e.ready) begin
        n_fails++;
        $display("FAIL read port %0d addr %0d: got data %h ready %b want data %h ready %b at %0t",
                 e.port, rd_addr[e.port*PW +: PW], rd_data[e.port*DATA_W +: DATA_W],
                 rd_ready[e.port], e.data, e.ready, $time);
      end
    end
  end

  task automatic clear_inputs();
    wr_valid = '0; wr_addr = '0; wr_data = '0;
    alloc_valid = '0; alloc_addr = '0;
    flush = 1'b0; collide_clr = 1'b0;
    for (int p = 0; p < NREAD; p++) rd_addr[p*PW +: PW] = PW'($urandom_range(0, NPREG - 1));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_wr(input int i, input int a, input logic [DATA_W-1:0] d);
    wr_valid[i] = 1'b1;
    wr_addr[i*PW +: PW] = PW'(a);
    wr_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic set_alloc(input int j, input int a);
    alloc_valid[j] = 1'b1;
    alloc_addr[j*PW +: PW] = PW'(a);
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*PW +: PW] = PW'(a);
  endtask

  task automatic randomize_inputs();
    clear_inputs();
    for (int i = 0; i < NWRITE; i++) begin
      if ($urandom_range(0, 1) == 1) set_wr(i, $urandom_range(0, 15), $urandom);
    end
    for (int j = 0; j < NALLOC; j++) begin
      if ($urandom_range(0, 2) == 0) set_alloc(j, $urandom_range(0, 15));
    end
    flush       = ($urandom_range(0, 15) == 0);
    collide_clr = ($urandom_range(0, 7) == 0);
    for (int p = 0; p < NREAD; p++) begin
      if ($urandom_range(0, 3) != 0) set_rd(p, $urandom_range(0, 15));
    end
  endtask

  initial begin
    model_reset();
    clear_inputs();
    #1 expect_now();
    tick();
    clear_inputs();
    expect_now();
    tick();
    rst = 1'b1;

    // Write then read
    clear_inputs(); set_wr(0, 5, 32'hDEADBEEF); set_rd(0, 5); expect_now(); tick();
    clear_inputs(); set_rd(0, 5); expect_now(); tick();

    // Collision, then clear
    clear_inputs(); set_wr(1, 9, 32'h11); set_wr(3, 9, 32'h33); expect_now(); tick();
    clear_inputs(); set_rd(2, 9); expect_now(); tick();
    clear_inputs(); collide_clr = 1'b1; expect_now(); tick();
    clear_inputs(); expect_now(); tick();

    // P0 protection
    clear_inputs(); set_wr(0, 0, 32'hFFFFFFFF); set_alloc(0, 0); expect_now(); tick();
    clear_inputs(); set_rd(0, 0); set_rd(9, 0); expect_now(); tick();

    // Scoreboard: alloc, write, alloc+write in one cycle
    clear_inputs(); set_alloc(1, 12); set_rd(0, 12); expect_now(); tick();
    clear_inputs(); set_rd(0, 12); set_wr(4, 12, 32'h7); expect_now(); tick();
    clear_inputs(); set_rd(0, 12); expect_now(); tick();
    clear_inputs(); set_alloc(0, 12); set_wr(2, 12, 32'h55); expect_now(); tick();
    clear_inputs(); set_rd(3, 12); expect_now(); tick();

    // Flush recovery
    clear_inputs(); set_alloc(0, 20); set_alloc(1, 21); expect_now(); tick();
    clear_inputs(); set_rd(0, 20); set_rd(1, 21); flush = 1'b1; set_alloc(0, 22);
    expect_now(); tick();
    clear_inputs(); set_rd(0, 20); set_rd(1, 21); set_rd(2, 22); expect_now(); tick();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      randomize_inputs();
      expect_now();
      tick();
    end

    // Asynchronous reset mid-cycle with writes pending
    randomize_inputs(); expect_now(); tick();
    randomize_inputs(); #2;
    rst = 1'b0;
    clear_inputs();
    model_reset();
    for (int p = 0; p < NREAD; p++) set_rd(p, $urandom_range(1, 15));
    #1 expect_now();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 50; c++) begin
      randomize_inputs();
      expect_now();
      tick();
    end

    clear_inputs();
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/prf_scoreboard.md
# prf_scoreboard

Parametrised physical register file for the out-of-order back end, combining data storage with a per-register ready scoreboard. It sits between rename (allocation), the issue queues (operand reads and ready polling) and the CDB (writeback). It generalises read and write port counts, register count and data width. It adds same-cycle write-to-read bypass, ready tracking with flush recovery, and a sticky write-collision flag.

## Interface
Parameters:
- DATA_W, 32, data width of each physical register
- NPREG, 64, number of physical registers (power of two, ≥ 4); PW = $clog2(NPREG)
- NREAD, 10, number of read ports
- NWRITE, 5, number of CDB write ports
- NALLOC, 2, number of rename allocation ports per cycle

Ports (vectors are flattened, port i occupies slice [i*W +: W]):
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- rd_addr  in  NREAD*PW  read addresses
- rd_data  out  NREAD*DATA_W  read data, combinational
- rd_ready  out  NREAD  scoreboard ready bit of rd_addr, combinational
- wr_valid  in  NWRITE  CDB write strobe (ready_cdb & RegWr_cdb)
- wr_addr  in  NWRITE*PW  CDB destination
- wr_data  in  NWRITE*DATA_W  CDB result
- alloc_valid  in  NALLOC  rename allocates a new destination
- alloc_addr  in  NALLOC*PW  allocated physical register
- flush  in  1  pipeline flush / mispredict recovery
- wr_collide  out  1  sticky: two write ports targeted the same nonzero register in one cycle
- collide_clr  in  1  clears wr_collide

## Operation
- Storage: NPREG×DATA_W data array plus NPREG ready bits.
- P0 is hardwired: reads return 0 with ready=1. Writes and allocations to P0 are ignored.
- Write: for each port i with wr_valid[i] and wr_addr[i]≠0, data[wr_addr[i]] ← wr_data[i] and ready ← 1 at the next clk edge.
- Same-address write collision: the highest-indexed port wins. wr_collide sets to 1 at the next edge.
- Allocation: alloc_valid[j] with alloc_addr[j]≠0 clears ready at the next edge. Data is unchanged.
- Allocation and write to the same register in one cycle: the clear wins for ready, and the data write still occurs.
- Two alloc ports with the same address behave as a single clear.
- Flush: at the next edge all ready bits become 1 and allocations in that cycle are ignored. Writes in the flush cycle still update data.
- wr_collide: collide_clr takes priority over a new set in the same cycle.
- Reset: the data array is all 0, every ready bit is 1, and wr_collide is 0. rd_data and rd_ready then follow the array, so at reset they read 0 and 1.

## Timing
- Reads are combinational from the array, with zero added latency.
- Writes and allocations take effect at the next posedge clk.
- Without bypass, a value written in cycle N is readable in cycle N+1.
- Allocate-to-not-ready latency is 1 cycle. Ready sampled in the allocation cycle still shows the old value.
- Asserting rst mid-cycle immediately returns the array, the ready bits and wr_collide to their reset values, regardless of pending writes.

## Configuration
- PRF_BYPASS_EN defined:
  - Each read port compares rd_addr against all wr_valid/wr_addr in the same cycle.
  - On a match (addr≠0), rd_data = wr_data of the highest-indexed matching port and rd_ready = 1.
  - This gives zero-cycle write-to-read visibility.
- PRF_BYPASS_EN undefined: no forwarding. Reads see array contents only, and rd_ready reflects the registered bit.

## Test plan
- Reset: assert rst=0 then release. Every read port at any address → rd_data=0, rd_ready=1, wr_collide=0.
- Write then read: wr_valid[0], addr 5, data 0xDEADBEEF in cycle N.
  - Cycle N+1: rd_addr=5 → 0xDEADBEEF, ready=1.
  - With PRF_BYPASS_EN, the same value also appears in cycle N.
- Collision: ports 1 and 3 write addr 9 with 0x11 and 0x33 → next cycle reads 0x33 and wr_collide=1. Pulse collide_clr → wr_collide=0.
- P0 protection: write 0xFFFFFFFF to addr 0 and alloc addr 0 → rd_addr=0 still returns 0, ready=1.
- Scoreboard:
  - Alloc addr 12 → next cycle rd_ready=0.
  - Write addr 12 = 0x7 → next cycle ready=1, data 0x7.
  - Alloc and write addr 12 in one cycle → ready=0, data updated.
- Flush: alloc addrs 20 and 21, then flush together with alloc addr 22 → next cycle ready=1 for 20, 21 and 22.
